// File: rtl/vending_pkg.sv
// ---------------------------------------------------------------------------
// vending_pkg
// Shared types and constants for the vending controller slice.
//   state_t        : controller states (IDLE, CREDIT, VEND, CHANGE)
//   COIN_UNIT      : smallest coin value; all credit and prices are multiples
//   QUARTER_VAL    : value of a quarter in cents
//   DOLLAR_VAL     : value of a dollar coin in cents
//   default_price  : reset price of a product given its index
// ---------------------------------------------------------------------------
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam int unsigned COIN_UNIT   = 25;
  localparam int unsigned QUARTER_VAL = 25;
  localparam int unsigned DOLLAR_VAL  = 100;

  // Price ladder used at reset: base price plus a fixed step per index.
  function automatic int unsigned default_price(input int unsigned idx,
                                                input int unsigned base,
                                                input int unsigned step);
    return base + idx * step;
  endfunction

endpackage

// File: rtl/vending_change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
// Loadable down-counter that hands out change one quarter at a time over a
// valid/ready handshake.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   load          : load load_cnt into the counter this cycle
//   load_cnt      : number of quarters to return
//   change_ready  : coin hopper accepts one quarter
//   change_valid  : a quarter is on offer (counter non-zero)
//   done          : the final quarter is being accepted this cycle
// ---------------------------------------------------------------------------
module change_dispenser #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             change_ready,
  output logic             change_valid,
  output logic             done
);

  logic [CNT_W-1:0] r_cnt;

  // Count down one quarter per accepted beat; a new load overrides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_cnt;
    end else if (change_valid && change_ready) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign change_valid = (r_cnt != '0);
  assign done         = change_valid && change_ready && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/vending_controller.sv
// ---------------------------------------------------------------------------
// vending_controller
// Multi-product vending controller: accumulates quarter/dollar credit,
// checks selections against a programmable price table, hands the chosen
// product to the dispenser over vend_valid/vend_ready and returns change as
// quarters through change_dispenser.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   coin_q, coin_d          : quarter / dollar inserted (single-cycle pulses)
//   cancel                  : refund request
//   sel_valid, sel_idx      : product selection strobe and index
//   price_we/idx/data       : price table write port
//   balance                 : current credit in cents
//   vend_valid/idx/ready    : dispense handshake
//   change_valid/ready      : one-quarter change handshake
//   coin_bounce             : pulse, an inserted coin was returned
//   reject                  : pulse, a selection was refused
//   busy                    : high while vending or returning change
// Optional build macro STOCK_TRACK_EN adds per-product stock counters with
// ports restock_we, restock_idx, restock_qty and sold_out.
// ---------------------------------------------------------------------------
module vending_controller
  import vending_pkg::*;
#(
  parameter  int unsigned NUM_PRODUCTS = 7,
  parameter  int unsigned BAL_W        = 10,
  parameter  int unsigned MAX_BALANCE  = 250,
  parameter  int unsigned BASE_PRICE   = 75,
  parameter  int unsigned PRICE_STEP   = 25,
  parameter  int unsigned STOCK_W      = 4,
  localparam int unsigned IDX_W        = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coin_q,
  input  logic             coin_d,
  input  logic             cancel,
  input  logic             sel_valid,
  input  logic [IDX_W-1:0] sel_idx,
  input  logic             price_we,
  input  logic [IDX_W-1:0] price_idx,
  input  logic [BAL_W-1:0] price_data,
  output logic [BAL_W-1:0] balance,
  output logic             vend_valid,
  output logic [IDX_W-1:0] vend_idx,
  input  logic             vend_ready,
  output logic             change_valid,
  input  logic             change_ready,
  output logic             coin_bounce,
  output logic             reject,
  output logic             busy
`ifdef STOCK_TRACK_EN
  ,
  input  logic                    restock_we,
  input  logic [IDX_W-1:0]        restock_idx,
  input  logic [STOCK_W-1:0]      restock_qty,
  output logic [NUM_PRODUCTS-1:0] sold_out
`endif
);

  localparam int unsigned    CNT_W   = $clog2(MAX_BALANCE / COIN_UNIT + 1);
  localparam logic [BAL_W:0] MAX_EXT = (BAL_W + 1)'(MAX_BALANCE);
  localparam logic [BAL_W:0] Q_EXT   = (BAL_W + 1)'(QUARTER_VAL);
  localparam logic [BAL_W:0] D_EXT   = (BAL_W + 1)'(DOLLAR_VAL);

  state_t           r_state;
  logic [BAL_W-1:0] r_balance;
  logic             r_vend_valid;
  logic [IDX_W-1:0] r_vend_idx;
  logic             r_coin_bounce;
  logic             r_reject;
  logic [BAL_W-1:0] r_price [NUM_PRODUCTS];

  logic             w_sel_in_range;
  logic [BAL_W-1:0] w_sel_price;
  logic             w_stock_ok;
  logic             w_sel_ok;
  logic [BAL_W:0]   w_sum_q;
  logic [BAL_W:0]   w_sum_d;
  logic             w_bounce_q;
  logic             w_bounce_d;
  logic             w_credit_state;
  logic             w_cancel_go;
  logic             w_vend_done;
  logic             w_load;
  logic [CNT_W-1:0] w_load_cnt;
  logic             w_change_valid;
  logic             w_change_done;
  logic             w_price_ok;

  // Selection qualification: index must exist and credit must cover price.
  assign w_sel_in_range = (int'(sel_idx) < int'(NUM_PRODUCTS));
  assign w_sel_price    = w_sel_in_range ? r_price[sel_idx] : '0;
  assign w_sel_ok       = w_sel_in_range && w_stock_ok && (r_balance >= w_sel_price);

  // Quarter is judged first, then the dollar against the updated total, so
  // a quarter that fits can still be kept when the dollar is bounced.
  always_comb begin
    w_sum_q    = {1'b0, r_balance};
    w_bounce_q = 1'b0;
    if (coin_q) begin
      if (w_sum_q + Q_EXT <= MAX_EXT) w_sum_q = w_sum_q + Q_EXT;
      else                            w_bounce_q = 1'b1;
    end
    w_sum_d    = w_sum_q;
    w_bounce_d = 1'b0;
    if (coin_d) begin
      if (w_sum_d + D_EXT <= MAX_EXT) w_sum_d = w_sum_d + D_EXT;
      else                            w_bounce_d = 1'b1;
    end
  end

  // Dispenser load happens on the same edge the FSM enters CHANGE, so the
  // first quarter is offered the cycle CHANGE becomes visible. In VEND the
  // balance register already holds the remainder.
  assign w_credit_state = (r_state == IDLE) || (r_state == CREDIT);
  assign w_cancel_go    = w_credit_state && cancel && (r_balance != '0);
  assign w_vend_done    = (r_state == VEND) && r_vend_valid && vend_ready;
  assign w_load         = w_cancel_go || (w_vend_done && (r_balance != '0));
  assign w_load_cnt     = CNT_W'(r_balance / BAL_W'(COIN_UNIT));

  change_dispenser #(
    .CNT_W (CNT_W)
  ) u_change (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (w_load),
    .load_cnt     (w_load_cnt),
    .change_ready (change_ready),
    .change_valid (w_change_valid),
    .done         (w_change_done)
  );

  // Main controller. Cancel beats selection beats coins; any coin arriving
  // while cancel or a selection wins, or while busy, is handed back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_balance     <= '0;
      r_vend_valid  <= 1'b0;
      r_vend_idx    <= '0;
      r_coin_bounce <= 1'b0;
      r_reject      <= 1'b0;
    end else begin
      r_coin_bounce <= 1'b0;
      r_reject      <= 1'b0;
      case (r_state)
        IDLE, CREDIT: begin
          if (w_cancel_go) begin
            r_balance     <= '0;
            r_state       <= CHANGE;
            r_coin_bounce <= coin_q || coin_d;
          end else if (sel_valid) begin
            r_coin_bounce <= coin_q || coin_d;
            if (w_sel_ok) begin
              r_balance    <= r_balance - w_sel_price;
              r_vend_valid <= 1'b1;
              r_vend_idx   <= sel_idx;
              r_state      <= VEND;
            end else begin
              r_reject <= 1'b1;
            end
          end else begin
            r_balance     <= w_sum_d[BAL_W-1:0];
            r_coin_bounce <= w_bounce_q || w_bounce_d;
            r_state       <= (w_sum_d != '0) ? CREDIT : IDLE;
          end
        end
        VEND: begin
          r_coin_bounce <= coin_q || coin_d;
          if (w_vend_done) begin
            r_vend_valid <= 1'b0;
            if (r_balance == '0) begin
              r_state <= IDLE;
            end else begin
              r_balance <= '0;
              r_state   <= CHANGE;
            end
          end
        end
        CHANGE: begin
          r_coin_bounce <= coin_q || coin_d;
          // Leaving on an empty counter guards against a zero-quarter load.
          if (w_change_done || !w_change_valid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Price table: only sane prices at existing indices are stored.
  assign w_price_ok = price_we
                   && (int'(price_idx) < int'(NUM_PRODUCTS))
                   && (price_data != '0)
                   && ((price_data % BAL_W'(COIN_UNIT)) == '0)
                   && (price_data <= BAL_W'(MAX_BALANCE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_PRODUCTS); i++) begin
        r_price[i] <= BAL_W'(default_price(unsigned'(i), BASE_PRICE, PRICE_STEP));
      end
    end else if (w_price_ok) begin
      r_price[price_idx] <= price_data;
    end
  end

`ifdef STOCK_TRACK_EN
  localparam logic [STOCK_W:0] STOCK_MAX = {1'b0, {STOCK_W{1'b1}}};

  logic [STOCK_W-1:0] r_stock      [NUM_PRODUCTS];
  logic [STOCK_W-1:0] w_stock_next [NUM_PRODUCTS];

  // Vend handshake takes one item; restock adds and saturates at full.
  always_comb begin
    for (int i = 0; i < int'(NUM_PRODUCTS); i++) begin : g_next
      logic [STOCK_W:0] v_sum;
      v_sum = {1'b0, r_stock[i]};
      if (w_vend_done && (int'(r_vend_idx) == i)) v_sum = v_sum - 1'b1;
      if (restock_we && (int'(restock_idx) == i)) v_sum = v_sum + {1'b0, restock_qty};
      w_stock_next[i] = (v_sum > STOCK_MAX) ? STOCK_MAX[STOCK_W-1:0] : v_sum[STOCK_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_PRODUCTS); i++) r_stock[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_PRODUCTS); i++) r_stock[i] <= w_stock_next[i];
    end
  end

  always_comb begin
    sold_out = '0;
    for (int i = 0; i < int'(NUM_PRODUCTS); i++) sold_out[i] = (r_stock[i] == '0);
  end

  assign w_stock_ok = w_sel_in_range && (r_stock[sel_idx] != '0);
`else
  assign w_stock_ok = 1'b1;
`endif

  assign balance      = r_balance;
  assign vend_valid   = r_vend_valid;
  assign vend_idx     = r_vend_idx;
  assign change_valid = w_change_valid;
  assign coin_bounce  = r_coin_bounce;
  assign reject       = r_reject;
  assign busy         = (r_state == VEND) || (r_state == CHANGE);

endmodule

// File: tb/tb_vending_controller.sv
// ---------------------------------------------------------------------------
// tb_vending_controller
// Self-checking bench for vending_controller (default build). A small
// behavioural model tracks credit in cents and the price list; each test
// task drives its scenario and compares DUT outputs against that model.
// ---------------------------------------------------------------------------
module tb_vending_controller;

  localparam int N     = 7;
  localparam int BAL_W = 10;
  localparam int IDX_W = 3;
  localparam int MAXB  = 250;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             coin_q = 1'b0;
  logic             coin_d = 1'b0;
  logic             cancel = 1'b0;
  logic             sel_valid = 1'b0;
  logic [IDX_W-1:0] sel_idx = '0;
  logic             price_we = 1'b0;
  logic [IDX_W-1:0] price_idx = '0;
  logic [BAL_W-1:0] price_data = '0;
  logic [BAL_W-1:0] balance;
  logic             vend_valid;
  logic [IDX_W-1:0] vend_idx;
  logic             vend_ready = 1'b0;
  logic             change_valid;
  logic             change_ready = 1'b0;
  logic             coin_bounce;
  logic             reject;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;
  int m_bal;
  int m_price [N];

  vending_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_q       (coin_q),
    .coin_d       (coin_d),
    .cancel       (cancel),
    .sel_valid    (sel_valid),
    .sel_idx      (sel_idx),
    .price_we     (price_we),
    .price_idx    (price_idx),
    .price_data   (price_data),
    .balance      (balance),
    .vend_valid   (vend_valid),
    .vend_idx     (vend_idx),
    .vend_ready   (vend_ready),
    .change_valid (change_valid),
    .change_ready (change_ready),
    .coin_bounce  (coin_bounce),
    .reject       (reject),
    .busy         (busy)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Absolute time limit so a stuck run still ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    coin_q = 1'b0; coin_d = 1'b0; cancel = 1'b0; sel_valid = 1'b0;
    price_we = 1'b0; vend_ready = 1'b0; change_ready = 1'b0;
  endtask

  // Model of coin acceptance: quarter first, then dollar, ceiling MAXB.
  function automatic bit model_coins(input bit q, input bit d);
    bit b = 1'b0;
    if (q) begin
      if (m_bal + 25 <= MAXB) m_bal += 25; else b = 1'b1;
    end
    if (d) begin
      if (m_bal + 100 <= MAXB) m_bal += 100; else b = 1'b1;
    end
    return b;
  endfunction

  function automatic void model_price(input int idx, input int data);
    if (idx < N && data != 0 && data % 25 == 0 && data <= MAXB) m_price[idx] = data;
  endfunction

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    m_bal = 0;
    for (int i = 0; i < N; i++) m_price[i] = 75 + 25 * i;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic insert(input bit q, input bit d);
    bit b;
    coin_q = q; coin_d = d;
    b = model_coins(q, d);
    tick();
    coin_q = 1'b0; coin_d = 1'b0;
  endtask

  task automatic add_credit(input int cents);
    int c = cents;
    while (c >= 100) begin insert(1'b0, 1'b1); c -= 100; end
    while (c >= 25)  begin insert(1'b1, 1'b0); c -= 25;  end
  endtask

  task automatic write_price(input int idx, input int data);
    price_we = 1'b1; price_idx = IDX_W'(idx); price_data = BAL_W'(data);
    model_price(idx, data);
    tick();
    price_we = 1'b0;
  endtask

  // Accept change quarters until the offer drops; optional random stalls.
  task automatic drain_change(input bit stall, output int beats, output bit tmo);
    beats = 0;
    tmo   = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (!change_valid) begin
        tmo = 1'b0;
        break;
      end
      change_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (change_ready) beats++;
      tick();
    end
    change_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #3;
    vectors++;
    if ({balance, vend_valid, vend_idx, change_valid, coin_bounce, reject, busy} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got bal=%0d vv=%b vi=%0d cv=%b cb=%b rj=%b bz=%b required all 0",
               balance, vend_valid, vend_idx, change_valid, coin_bounce, reject, busy);
    end
    do_reset();
  endtask

  task automatic test_credit_ceiling();
    do_reset();
    insert(1'b0, 1'b1); insert(1'b0, 1'b1); insert(1'b1, 1'b0); insert(1'b1, 1'b0);
    vectors++;
    if (balance !== BAL_W'(250)) begin
      miscompares++; $display("[TB] FAIL fill_250: got %0d required 250", balance);
    end
    coin_q = 1'b1; tick(); coin_q = 1'b0;
    vectors++;
    if (coin_bounce !== 1'b1 || balance !== BAL_W'(250)) begin
      miscompares++; $display("[TB] FAIL over_ceiling: got cb=%b bal=%0d required cb=1 bal=250", coin_bounce, balance);
    end
    coin_q = 1'b1; coin_d = 1'b1; tick(); coin_q = 1'b0; coin_d = 1'b0;
    vectors++;
    if (coin_bounce !== 1'b1 || balance !== BAL_W'(250)) begin
      miscompares++; $display("[TB] FAIL double_bounce: got cb=%b bal=%0d required cb=1 bal=250", coin_bounce, balance);
    end
    tick();
    vectors++;
    if (coin_bounce !== 1'b0) begin
      miscompares++; $display("[TB] FAIL bounce_single_pulse: got %b required 0", coin_bounce);
    end
  endtask

  task automatic test_vend_change();
    int beats; bit tmo;
    do_reset();
    add_credit(200);
    sel_valid = 1'b1; sel_idx = 3'd2; tick(); sel_valid = 1'b0;
    vectors++;
    if (vend_valid !== 1'b1 || vend_idx !== 3'd2 || balance !== BAL_W'(200 - m_price[2]) || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL vend_start: got vv=%b vi=%0d bal=%0d bz=%b required vv=1 vi=2 bal=%0d bz=1",
               vend_valid, vend_idx, balance, busy, 200 - m_price[2]);
    end
    for (int k = 0; k < 3; k++) begin
      coin_q = (k == 1);
      tick();
      coin_q = 1'b0;
      vectors++;
      if (vend_valid !== 1'b1 || vend_idx !== 3'd2) begin
        miscompares++; $display("[TB] FAIL vend_hold: got vv=%b vi=%0d required vv=1 vi=2", vend_valid, vend_idx);
      end
      if (k == 1) begin
        vectors++;
        if (coin_bounce !== 1'b1 || balance !== BAL_W'(75)) begin
          miscompares++; $display("[TB] FAIL coin_in_vend: got cb=%b bal=%0d required cb=1 bal=75", coin_bounce, balance);
        end
      end
    end
    vend_ready = 1'b1; tick(); vend_ready = 1'b0;
    vectors++;
    if (vend_valid !== 1'b0 || change_valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL vend_to_change: got vv=%b cv=%b required vv=0 cv=1", vend_valid, change_valid);
    end
    drain_change(1'b0, beats, tmo);
    vectors++;
    if (tmo || beats != 3 || busy !== 1'b0 || balance !== '0) begin
      miscompares++; $display("[TB] FAIL vend_change_beats: got beats=%0d tmo=%b bz=%b bal=%0d required 3 0 0 0",
                              beats, tmo, busy, balance);
    end
  endtask

  task automatic test_reject_cancel();
    int beats; bit tmo;
    do_reset();
    add_credit(100);
    sel_valid = 1'b1; sel_idx = 3'd6; tick(); sel_valid = 1'b0;
    vectors++;
    if (reject !== 1'b1 || balance !== BAL_W'(100) || vend_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reject_pulse: got rj=%b bal=%0d vv=%b bz=%b required 1 100 0 0",
                              reject, balance, vend_valid, busy);
    end
    tick();
    vectors++;
    if (reject !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reject_width: got %b required 0", reject);
    end
    sel_valid = 1'b1; sel_idx = 3'd7; tick(); sel_valid = 1'b0;
    vectors++;
    if (reject !== 1'b1 || vend_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reject_range: got rj=%b vv=%b required rj=1 vv=0", reject, vend_valid);
    end
    cancel = 1'b1; tick(); cancel = 1'b0;
    drain_change(1'b1, beats, tmo);
    vectors++;
    if (tmo || beats != 4 || balance !== '0) begin
      miscompares++; $display("[TB] FAIL cancel_beats: got beats=%0d tmo=%b bal=%0d required 4 0 0", beats, tmo, balance);
    end
  endtask

  task automatic test_cancel_priority();
    int beats; bit tmo; bit saw_vend;
    do_reset();
    add_credit(150);
    cancel = 1'b1; sel_valid = 1'b1; sel_idx = 3'd0; tick();
    cancel = 1'b0; sel_valid = 1'b0;
    saw_vend = vend_valid;
    drain_change(1'b0, beats, tmo);
    vectors++;
    if (tmo || beats != 6 || saw_vend !== 1'b0) begin
      miscompares++; $display("[TB] FAIL cancel_over_select: got beats=%0d vv=%b tmo=%b required 6 0 0", beats, saw_vend, tmo);
    end
  endtask

  task automatic test_price_write();
    do_reset();
    write_price(0, 50);
    add_credit(50);
    sel_valid = 1'b1; sel_idx = 3'd0; tick(); sel_valid = 1'b0;
    vectors++;
    if (vend_valid !== 1'b1 || balance !== '0) begin
      miscompares++; $display("[TB] FAIL new_price_vend: got vv=%b bal=%0d required vv=1 bal=0", vend_valid, balance);
    end
    vend_ready = 1'b1; tick(); vend_ready = 1'b0;
    vectors++;
    if (change_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL exact_no_change: got cv=%b bz=%b required 0 0", change_valid, busy);
    end
    write_price(0, 60);
    add_credit(50);
    sel_valid = 1'b1; sel_idx = 3'd0; tick(); sel_valid = 1'b0;
    vectors++;
    if (vend_valid !== 1'b1 || reject !== 1'b0 || m_price[0] != 50) begin
      miscompares++; $display("[TB] FAIL bad_price_ignored: got vv=%b rj=%b required vv=1 rj=0", vend_valid, reject);
    end
    vend_ready = 1'b1; tick(); vend_ready = 1'b0;
  endtask

  task automatic test_reset_mid_change();
    int seen = 0;
    do_reset();
    add_credit(75);
    cancel = 1'b1; tick(); cancel = 1'b0;
    vectors++;
    if (change_valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL change_pending: got %b required 1", change_valid);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({balance, vend_valid, vend_idx, change_valid, coin_bounce, reject, busy} !== '0) begin
      miscompares++; $display("[TB] FAIL async_reset: got bal=%0d cv=%b bz=%b required all 0", balance, change_valid, busy);
    end
    tick();
    rst_n = 1'b1;
    m_bal = 0;
    change_ready = 1'b1;
    repeat (5) begin
      tick();
      if (change_valid) seen++;
    end
    change_ready = 1'b0;
    vectors++;
    if (seen != 0) begin
      miscompares++; $display("[TB] FAIL change_after_reset: got %0d beats required 0", seen);
    end
  endtask

  task automatic test_random();
    int beats; bit tmo; bit exp_b; int idx; int rem;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      for (int c = 0; c < int'($urandom_range(1, 6)); c++) begin
        coin_q = 1'($urandom_range(0, 1));
        coin_d = 1'($urandom_range(0, 1));
        exp_b = model_coins(coin_q, coin_d);
        tick();
        coin_q = 1'b0; coin_d = 1'b0;
        vectors++;
        if (balance !== BAL_W'(m_bal) || coin_bounce !== exp_b) begin
          miscompares++; $display("[TB] FAIL rand_coin: got bal=%0d cb=%b required bal=%0d cb=%b",
                                  balance, coin_bounce, m_bal, exp_b);
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) write_price(int'($urandom_range(0, 7)), 25 * int'($urandom_range(0, 12)));
        else                           write_price(int'($urandom_range(0, 7)), int'($urandom_range(0, 300)));
      end
      if ($urandom_range(0, 3) == 0) begin
        rem = m_bal;
        cancel = 1'b1; tick(); cancel = 1'b0;
        drain_change(1'b1, beats, tmo);
        vectors++;
        if (tmo || beats != rem / 25 || balance !== '0 || busy !== 1'b0) begin
          miscompares++; $display("[TB] FAIL rand_cancel: got beats=%0d bal=%0d required beats=%0d bal=0", beats, balance, rem / 25);
        end
        m_bal = 0;
      end else begin
        idx = int'($urandom_range(0, 7));
        sel_valid = 1'b1; sel_idx = IDX_W'(idx); tick(); sel_valid = 1'b0;
        if (idx < N && m_bal >= m_price[idx]) begin
          rem = m_bal - m_price[idx];
          vectors++;
          if (vend_valid !== 1'b1 || vend_idx !== IDX_W'(idx) || balance !== BAL_W'(rem)) begin
            miscompares++; $display("[TB] FAIL rand_vend: got vv=%b vi=%0d bal=%0d required vv=1 vi=%0d bal=%0d",
                                    vend_valid, vend_idx, balance, idx, rem);
          end
          repeat ($urandom_range(0, 3)) tick();
          vend_ready = 1'b1; tick(); vend_ready = 1'b0;
          drain_change(1'b1, beats, tmo);
          vectors++;
          if (tmo || beats != rem / 25 || vend_valid !== 1'b0 || busy !== 1'b0 || balance !== '0) begin
            miscompares++; $display("[TB] FAIL rand_change: got beats=%0d vv=%b bz=%b required beats=%0d vv=0 bz=0",
                                    beats, vend_valid, busy, rem / 25);
          end
          m_bal = 0;
        end else begin
          vectors++;
          if (reject !== 1'b1 || vend_valid !== 1'b0 || balance !== BAL_W'(m_bal)) begin
            miscompares++; $display("[TB] FAIL rand_reject: got rj=%b vv=%b bal=%0d required rj=1 vv=0 bal=%0d",
                                    reject, vend_valid, balance, m_bal);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_credit_ceiling();
    test_vend_change();
    test_reject_cancel();
    test_cancel_priority();
    test_price_write();
    test_reset_mid_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
